// File: rtl/serial_input_pkg.sv
// serial_input_pkg: shared types and constants for the UART receive front-end.
// FSM state encoding, character geometry and the baud divisor helper.
package serial_input_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_e;

    localparam int DATA_BITS         = 8;
    localparam int OVERSAMPLE        = 16;
    localparam int FIFO_DEPTH        = 4;
    localparam int FRAMING_ERROR_BIT = 8;

    localparam int CHAR_W      = DATA_BITS + 1;
    localparam int PTR_W       = $clog2(FIFO_DEPTH);
    localparam int WORD_W      = 32;
    localparam int START_TICKS = OVERSAMPLE / 2;

    typedef logic [CHAR_W-1:0] char_t;

    // Clocks per oversample tick, never below one.
    function automatic int calc_divisor(input int clk_hz, input int baud);
        int d;
        d = clk_hz / (baud * OVERSAMPLE);
        return (d < 1) ? 1 : d;
    endfunction

endpackage

// File: rtl/serial_input_fifo.sv
// serial_input_fifo: small character FIFO between the receiver and the
// output handshake; a push into a full FIFO is taken when a pop coincides.
module serial_input_fifo
    import serial_input_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  push_i,
    input  char_t data_i,
    input  logic  pop_i,
    output char_t data_o,
    output logic  full_o,
    output logic  empty_o
);

    localparam logic [PTR_W:0] CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0] CNT_FULL = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    char_t            mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_q;
    logic [PTR_W-1:0] rd_q;
    logic [PTR_W:0]   cnt_q;
    logic [PTR_W:0]   cnt_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (cnt_q == CNT_FULL);
    assign empty_o = (cnt_q == '0);
    assign data_o  = mem_q[rd_q];

    // Accept a pop only with data present; a push needs room or a same-cycle pop.
    always_comb begin
        do_pop  = pop_i && !empty_o;
        do_push = push_i && (!full_o || do_pop);
        cnt_d   = cnt_q;
        unique case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CNT_ONE;
            2'b01:   cnt_d = cnt_q - CNT_ONE;
            default: cnt_d = cnt_q;
        endcase
    end

    // Storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= data_i;
                wr_q        <= wr_q + PTR_ONE;
            end
            if (do_pop) begin
                rd_q <= rd_q + PTR_ONE;
            end
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/serial_input.sv
// serial_input: 16x oversampling 8N1 UART receiver with stb/ack word output.
// Define SERIAL_INPUT_FIFO_EN to buffer up to 4 characters ahead of the output.
module serial_input
    import serial_input_pkg::*;
#(
    parameter int CLOCK_FREQUENCY = 100000000,
    parameter int BAUD_RATE       = 115200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx,
    output logic [31:0] out,
    output logic        out_stb,
    input  logic        out_ack,
    output logic        overrun
);

    localparam int DIVISOR = calc_divisor(CLOCK_FREQUENCY, BAUD_RATE);
    localparam int DIV_W   = $clog2(DIVISOR + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIVISOR - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam logic [3:0] START_LAST = 4'(START_TICKS - 1);
    localparam logic [3:0] BIT_LAST   = 4'(OVERSAMPLE - 1);
    localparam logic [2:0] DATA_LAST  = 3'(DATA_BITS - 1);
    localparam int         PAD_W      = WORD_W - CHAR_W;

    logic sync1_q;
    logic sync2_q;
    logic rx_s;

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;
    logic             tick;

    state_e   state_q;
    state_e   state_d;
    logic [3:0] cnt_q;
    logic [3:0] cnt_d;
    logic [2:0] bit_q;
    logic [2:0] bit_d;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] shift_d;
    logic prev_q;
    logic prev_d;

    logic  push;
    char_t push_data;
    logic  ack_fire;
    logic  ovr_set;
    logic  ovr_q;

    assign rx_s     = sync2_q;
    assign ack_fire = out_stb && out_ack;
    assign overrun  = ovr_q;

    // Two-flop synchroniser; idles high so reset does not look like a start bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= rx;
            sync2_q <= sync1_q;
        end
    end

    // Free-running divider producing one oversample tick per DIVISOR clocks.
    always_comb begin
        tick  = (div_q == DIV_LAST);
        div_d = tick ? '0 : div_q + DIV_ONE;
    end

    // Divider register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    // Receive FSM: advances only on ticks; emits the character at the stop sample.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        prev_d    = prev_q;
        push      = 1'b0;
        push_data = '0;
        push_data[DATA_BITS-1:0]    = shift_q;
        push_data[FRAMING_ERROR_BIT] = ~rx_s;
        if (tick) begin
            prev_d = rx_s;
            unique case (state_q)
                IDLE: begin
                    if (!rx_s && prev_q) begin
                        state_d = START;
                        cnt_d   = '0;
                    end
                end
                START: begin
                    if (cnt_q == START_LAST) begin
                        cnt_d = '0;
                        if (rx_s) begin
                            state_d = IDLE;
                        end else begin
                            state_d = DATA;
                            bit_d   = '0;
                        end
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                DATA: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_d   = '0;
                        shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                        if (bit_q == DATA_LAST) begin
                            state_d = STOP;
                        end else begin
                            bit_d = bit_q + 3'd1;
                        end
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                STOP: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_d   = '0;
                        push    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // FSM state and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            prev_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            prev_q  <= prev_d;
        end
    end

`ifdef SERIAL_INPUT_FIFO_EN
    char_t fifo_head;
    logic  fifo_full;
    logic  fifo_empty;

    serial_input_fifo u_fifo (
        .clk     (clk),
        .rst_n   (rst),
        .push_i  (push),
        .data_i  (push_data),
        .pop_i   (ack_fire),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign out_stb = !fifo_empty;
    assign out     = fifo_empty ? '0 : {{PAD_W{1'b0}}, fifo_head};
    assign ovr_set = push && fifo_full && !ack_fire;
`else
    char_t hold_q;
    char_t hold_d;
    logic  stb_q;
    logic  stb_d;

    // Single holding register: load when empty or being drained, else drop.
    always_comb begin
        hold_d  = hold_q;
        stb_d   = stb_q;
        ovr_set = 1'b0;
        if (push) begin
            if (!stb_q || ack_fire) begin
                hold_d = push_data;
                stb_d  = 1'b1;
            end else begin
                ovr_set = 1'b1;
            end
        end else if (ack_fire) begin
            stb_d = 1'b0;
        end
    end

    // Holding register state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_q <= '0;
            stb_q  <= 1'b0;
        end else begin
            hold_q <= hold_d;
            stb_q  <= stb_d;
        end
    end

    assign out_stb = stb_q;
    assign out     = {{PAD_W{1'b0}}, hold_q};
`endif

    // Sticky overrun flag; only reset clears it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovr_q <= 1'b0;
        end else if (ovr_set) begin
            ovr_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_serial_input.sv
// tb_serial_input: randomized + directed bench with a character-level model
// and a scoreboard monitor comparing every accepted output word.
module tb_serial_input;

    localparam int CLK_HZ   = 1600000;
    localparam int BAUD     = 100000;
    localparam int BIT_CLKS = 16;
`ifdef SERIAL_INPUT_FIFO_EN
    localparam int CAP = 4;
`else
    localparam int CAP = 1;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rx = 1'b1;
    logic        out_ack = 1'b0;
    logic [31:0] out;
    logic        out_stb;
    logic        overrun;

    serial_input #(
        .CLOCK_FREQUENCY(CLK_HZ),
        .BAUD_RATE(BAUD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rx(rx),
        .out(out),
        .out_stb(out_stb),
        .out_ack(out_ack),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    int unsigned cyc = 0;
    int unsigned start_cyc = 0;
    int          stb_hi = 0;
    logic [8:0]  exp_q[$];
    bit          exp_ovr = 1'b0;
    bit          ack_free = 1'b1;
    bit          ack_rand = 1'b0;
    bit          held = 1'b0;
    logic [31:0] held_out = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    // Character-level model: a character is delivered unless the consumer is
    // stalled and the buffer already holds CAP characters.
    task automatic model_char(input logic [7:0] b, input bit stop_ok);
        if (!ack_free && exp_q.size() >= CAP) exp_ovr = 1'b1;
        else exp_q.push_back({~stop_ok, b});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (ack_rand) out_ack = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input logic [7:0] b, input bit stop_ok);
        model_char(b, stop_ok);
        step();
        rx = 1'b0;
        start_cyc = cyc;
        for (int i = 0; i < 8; i++) begin
            repeat (BIT_CLKS) step();
            rx = b[i];
        end
        repeat (BIT_CLKS) step();
        rx = stop_ok;
        repeat (BIT_CLKS) step();
        rx = 1'b1;
        repeat (4 + $urandom_range(0, 12)) step();
    endtask

    // Start bit plus nbits data bits, then extra clocks into the next bit.
    task automatic send_partial(input logic [7:0] b, input int nbits,
                                input int extra);
        step();
        rx = 1'b0;
        repeat (BIT_CLKS) step();
        for (int i = 0; i < nbits; i++) begin
            rx = b[i];
            repeat (BIT_CLKS) step();
        end
        rx = b[nbits];
        repeat (extra) step();
    endtask

    task automatic do_reset();
        step();
        rst = 1'b0;
        rx = 1'b1;
        out_ack = 1'b0;
        ack_rand = 1'b0;
        exp_q.delete();
        exp_ovr = 1'b0;
        repeat (3) step();
        rst = 1'b1;
        repeat (3) step();
    endtask

    task automatic drain(input string name);
        ack_rand = 1'b0;
        out_ack = 1'b1;
        for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(negedge clk);
        repeat (5) step();
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    // Scoreboard monitor: compares each accepted word and output stability.
    always @(negedge clk) begin
        if (!rst) begin
            held = 1'b0;
        end else begin
            if (out_stb) stb_hi++;
            if (held) begin
                check("hold_stb", 32'(out_stb), 32'd1);
                check("hold_out", out, held_out);
            end
            if (out_stb && out_ack) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got 0x%08h, expected none", out);
                end else begin
                    check("word", out, {23'b0, exp_q.pop_front()});
                end
            end
            held = out_stb && !out_ack;
            held_out = out;
        end
    end

    initial begin
        int s0;
        int lat;
        logic [7:0] rb;
        bit rs;

        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_out", out, 32'd0);
        check("reset_stb", 32'(out_stb), 32'd0);
        check("reset_ovr", 32'(overrun), 32'd0);
        rst = 1'b1;
        repeat (3) step();

        // 0x55, ack tied high: latency and single-cycle strobe
        ack_free = 1'b1;
        out_ack = 1'b1;
        s0 = stb_hi;
        lat = -1;
        fork
            send(8'h55, 1'b1);
            begin
                for (int i = 0; i < 400; i++) begin
                    @(negedge clk);
                    if (out_stb) begin
                        lat = int'(cyc - start_cyc);
                        break;
                    end
                end
            end
        join
        check("latency_55", 32'(lat), 32'd155);
        drain("drain_55");
        check("stb_width_55", 32'(stb_hi - s0), 32'd1);
        check("ovr_55", 32'(overrun), 32'd0);

        // framing error
        send(8'hA3, 1'b0);
        drain("drain_a3");

        // short glitch must not start a character
        s0 = stb_hi;
        step();
        rx = 1'b0;
        repeat (4) step();
        rx = 1'b1;
        repeat (40) step();
        check("glitch_stb", 32'(stb_hi - s0), 32'd0);
        send(8'h3C, 1'b1);
        drain("drain_after_glitch");

        // stalled consumer, two characters
        do_reset();
        ack_free = 1'b0;
        send(8'h11, 1'b1);
        send(8'h22, 1'b1);
        repeat (4) step();
        check("stall_out", out, 32'h11);
        check("stall_stb", 32'(out_stb), 32'd1);
        check("stall_ovr", 32'(overrun), 32'(exp_ovr));
        out_ack = 1'b1;
        step();
        out_ack = 1'b0;
        repeat (4) step();
        check("stb_after_ack", 32'(out_stb), 32'(exp_q.size() != 0));
        drain("drain_stall2");
        check("stall2_ovr_end", 32'(overrun), 32'(exp_ovr));

        // stalled consumer, five characters
        do_reset();
        ack_free = 1'b0;
        for (int b = 1; b <= 5; b++) send(8'(b), 1'b1);
        check("stall5_ovr", 32'(overrun), 32'(exp_ovr));
        check("stall5_stb", 32'(out_stb), 32'd1);
        check("stall5_head", out, 32'h01);
        drain("drain_stall5");
        check("stall5_ovr_end", 32'(overrun), 32'(exp_ovr));

        // reset in the middle of bit 3 discards the partial character
        do_reset();
        send_partial(8'h7E, 3, 8);
        do_reset();
        ack_free = 1'b1;
        out_ack = 1'b1;
        send(8'h42, 1'b1);
        drain("drain_after_reset");
        check("reset_mid_ovr", 32'(overrun), 32'd0);

        // randomized characters with random consumer acks
        do_reset();
        ack_free = 1'b1;
        ack_rand = 1'b1;
        for (int n = 0; n < 24; n++) begin
            rb = 8'($urandom_range(0, 255));
            rs = ($urandom_range(0, 3) != 0);
            send(rb, rs);
        end
        drain("drain_random");
        check("random_ovr", 32'(overrun), 32'(exp_ovr));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
